// File: rtl/multi_timed_enable.sv
// Multi-channel periodic/one-shot enable generator: each channel counts its own
// runtime-programmable period and emits a registered one-clock enable pulse.
module multi_timed_enable #(
  parameter int  CHANNELS       = 4,
  parameter int  WIDTH          = 24,
  parameter int  DEFAULT_PERIOD = 6_000_000,
  localparam int SELW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SELW-1:0]     cfg_sel,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] running
);

  localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic             oneshot_q, oneshot_d;
    logic             act_oneshot_q, act_oneshot_d;
    logic             enable_q, enable_d;
    logic             cfg_hit;
    logic [WIDTH-1:0] peff;
    logic             terminal;

    // An out-of-range cfg_sel matches no channel, so the write is dropped.
    assign cfg_hit = cfg_we && (cfg_sel == SELW'(i));

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      period_d      = cfg_hit ? cfg_period  : period_q;
      oneshot_d     = cfg_hit ? cfg_oneshot : oneshot_q;
      peff          = (act_period_q == '0) ? WIDTH'(1) : act_period_q;
      terminal      = (count_q == peff - WIDTH'(1));
      state_d       = state_q;
      count_d       = count_q;
      act_period_d  = act_period_q;
      act_oneshot_d = act_oneshot_q;
      enable_d      = 1'b0;

      // Stop outranks start even in IDLE, so a simultaneous start is discarded.
      if (stop[i]) begin
        state_d = IDLE;
        count_d = '0;
      end else if (start[i]) begin
        // Start sees a same-cycle config write to this channel.
        state_d       = RUN;
        count_d       = '0;
        act_period_d  = period_d;
        act_oneshot_d = oneshot_d;
      end else if (state_q == RUN) begin
        if (terminal) begin
          enable_d      = 1'b1;
          count_d       = '0;
          act_period_d  = period_q;
          act_oneshot_d = oneshot_q;
          if (act_oneshot_q) state_d = IDLE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    // NOTE: the per-channel config registers are few and small, so they are
    // reset along with the datapath rather than left uninitialised.
    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q       <= IDLE;
        count_q       <= '0;
        period_q      <= DEF_PERIOD;
        oneshot_q     <= 1'b0;
        act_period_q  <= DEF_PERIOD;
        act_oneshot_q <= 1'b0;
        enable_q      <= 1'b0;
      end else begin
        state_q       <= state_d;
        count_q       <= count_d;
        period_q      <= period_d;
        oneshot_q     <= oneshot_d;
        act_period_q  <= act_period_d;
        act_oneshot_q <= act_oneshot_d;
        enable_q      <= enable_d;
      end
    end

    assign enable[i]  = enable_q;
    assign running[i] = (state_q == RUN);
  end

endmodule

// File: tb/tb_multi_timed_enable.sv
// Bench for multi_timed_enable: vector table, hand-written corner sequences and
// a randomized run compared against an absolute-time reference model.
module tb_multi_timed_enable;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int DEF = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [W-1:0]  cfg_period;
  logic          cfg_oneshot;
  logic [CH-1:0] start, stop, enable, running;

  logic          o_cfg_we;
  logic [1:0]    o_cfg_sel;
  logic [W-1:0]  o_cfg_period;
  logic          o_cfg_oneshot;
  logic [2:0]    o_start, o_stop, o_enable, o_running;

  int n_err   = 0;
  int n_check = 0;

  always #5 clock = ~clock;

  multi_timed_enable #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(DEF)) u_dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start),
    .stop(stop), .enable(enable), .running(running)
  );

  // Three channels so a 2-bit select can address a non-existent channel.
  multi_timed_enable #(.CHANNELS(3), .WIDTH(W), .DEFAULT_PERIOD(DEF)) u_odd (
    .clock(clock), .reset(reset), .cfg_we(o_cfg_we), .cfg_sel(o_cfg_sel),
    .cfg_period(o_cfg_period), .cfg_oneshot(o_cfg_oneshot), .start(o_start),
    .stop(o_stop), .enable(o_enable), .running(o_running)
  );

  typedef struct {
    logic          rn;
    logic          we;
    logic [1:0]    sel;
    logic [W-1:0]  per;
    logic          os;
    logic [CH-1:0] st;
    logic [CH-1:0] sp;
    logic [CH-1:0] exp_en;
    logic [CH-1:0] exp_run;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic apply(input logic rn, input logic we, input logic [1:0] sel,
                       input logic [W-1:0] per, input logic os,
                       input logic [CH-1:0] st, input logic [CH-1:0] sp);
    reset = rn; cfg_we = we; cfg_sel = sel; cfg_period = per; cfg_oneshot = os;
    start = st; stop = sp;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, '0);
  endtask

  task automatic add(input logic rn, input logic we, input logic [1:0] sel,
                     input logic [W-1:0] per, input logic os, input logic [CH-1:0] st,
                     input logic [CH-1:0] sp, input logic [CH-1:0] en, input logic [CH-1:0] run);
    vec_t v;
    v.rn = rn; v.we = we; v.sel = sel; v.per = per; v.os = os;
    v.st = st; v.sp = sp; v.exp_en = en; v.exp_run = run;
    vecs.push_back(v);
  endtask

  // Reference model: each running channel remembers the absolute cycle of its
  // next pulse; a wrap schedules the following one a full period later.
  int m_t;
  bit m_run[CH];
  int m_next[CH];
  int m_ap[CH];
  bit m_aos[CH];
  int m_per[CH];
  bit m_os[CH];

  function automatic int peff(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_step(input logic rn, input logic we, input logic [1:0] sel,
                            input int per, input logic os, input logic [CH-1:0] st,
                            input logic [CH-1:0] sp, output logic [CH-1:0] e_en,
                            output logic [CH-1:0] e_run);
    m_t++;
    for (int c = 0; c < CH; c++) begin
      e_en[c] = 1'b0;
      if (!rn) begin
        m_run[c] = 0; m_per[c] = DEF; m_os[c] = 0; m_ap[c] = DEF; m_aos[c] = 0;
      end else begin
        int np;
        bit nos;
        np  = (we && int'(sel) == c) ? per : m_per[c];
        nos = (we && int'(sel) == c) ? os  : m_os[c];
        if (sp[c]) begin
          m_run[c] = 0;
        end else if (st[c]) begin
          m_run[c] = 1; m_ap[c] = np; m_aos[c] = nos;
          m_next[c] = m_t + peff(np);
        end else if (m_run[c] && m_t == m_next[c]) begin
          e_en[c] = 1'b1;
          if (m_aos[c]) m_run[c] = 0;
          m_ap[c] = m_per[c]; m_aos[c] = m_os[c];
          m_next[c] = m_t + peff(m_ap[c]);
        end
        m_per[c] = np; m_os[c] = nos;
      end
      e_run[c] = m_run[c];
    end
  endtask

  initial begin
    logic [CH-1:0] e_en, e_run;
    reset = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_period = '0; cfg_oneshot = 1'b0;
    start = '0; stop = '0;
    o_cfg_we = 1'b0; o_cfg_sel = '0; o_cfg_period = '0; o_cfg_oneshot = 1'b0;
    o_start = '0; o_stop = '0;

    // Table: ch0 periodic at default 5; ch1 one-shot 3 written in its start cycle.
    add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    for (int k = 2; k <= 5; k++) add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0000, 4'b0001);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0001, 4'b0001);
    for (int k = 7; k <= 10; k++) add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0000, 4'b0001);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0001, 4'b0001);
    add(1, 1, 1, 3, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0011);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0000, 4'b0011);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0000, 4'b0011);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0010, 4'b0001);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0001, 4'b0001);
    for (int k = 17; k <= 20; k++) add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0000, 4'b0001);
    add(1, 0, 0, 0, 0, 4'b0, 4'b0, 4'b0001, 4'b0001);

    foreach (vecs[v]) begin
      apply(vecs[v].rn, vecs[v].we, vecs[v].sel, vecs[v].per, vecs[v].os, vecs[v].st, vecs[v].sp);
      check($sformatf("vec%0d_enable", v), 32'(enable), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].exp_run));
    end

    // Ch2 period 4; period 7 written mid-interval applies only after the wrap.
    apply(1, 1, 2, 4, 0, 4'b0100, 4'b0000);
    for (int t = 1; t <= 18; t++) begin
      if (t == 2) apply(1, 1, 2, 7, 0, 4'b0, 4'b0);
      else        idle();
      check($sformatf("ch2_retime_t%0d", t), 32'(enable[2]), 32'(t == 4 || t == 11 || t == 18));
      check($sformatf("ch2_run_t%0d", t), 32'(running[2]), 32'd1);
    end

    // Ch0: stop plus start on the terminal count wins; then a clean restart.
    apply(0, 0, 0, 0, 0, 4'b0, 4'b0);
    apply(1, 0, 0, 0, 0, 4'b0001, 4'b0000);
    for (int t = 1; t <= 4; t++) idle();
    apply(1, 0, 0, 0, 0, 4'b0001, 4'b0001);
    check("stop_term_enable", 32'(enable[0]), 32'd0);
    check("stop_term_running", 32'(running[0]), 32'd0);
    for (int t = 1; t <= 3; t++) begin
      idle();
      check($sformatf("stopped_t%0d", t), 32'({enable[0], running[0]}), 32'd0);
    end
    apply(1, 0, 0, 0, 0, 4'b0001, 4'b0000);
    for (int t = 1; t <= 5; t++) begin
      idle();
      check($sformatf("restart_t%0d", t), 32'(enable[0]), 32'(t == 5));
    end

    // Ch3 period 0 then 1: enable every cycle; restart forces one low cycle.
    apply(0, 0, 0, 0, 0, 4'b0, 4'b0);
    apply(1, 1, 3, 0, 0, 4'b1000, 4'b0000);
    for (int t = 1; t <= 4; t++) begin
      idle();
      check($sformatf("p0_en_t%0d", t), 32'(enable), 32'h8);
    end
    apply(1, 1, 3, 1, 0, 4'b0, 4'b0);
    check("p0_cfg_keeps_rate", 32'(enable[3]), 32'd1);
    apply(1, 0, 0, 0, 0, 4'b1000, 4'b0000);
    check("p1_restart_low", 32'(enable[3]), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      idle();
      check($sformatf("p1_en_t%0d", t), 32'(enable), 32'h8);
    end

    // Out-of-range select on a 3-channel instance leaves every channel at default.
    apply(0, 0, 0, 0, 0, 4'b0, 4'b0);
    o_cfg_we = 1'b1; o_cfg_sel = 2'd3; o_cfg_period = 8'd2;
    idle();
    o_cfg_we = 1'b0; o_start = 3'b111;
    idle();
    o_start = 3'b000;
    for (int t = 1; t <= 5; t++) begin
      idle();
      check($sformatf("oor_sel_t%0d", t), 32'(o_enable), (t == 5) ? 32'h7 : 32'h0);
    end

    // Reset while all channels run restores default periods.
    for (int c = 0; c < CH; c++) apply(1, 1, 2'(c), 8'd2, 0, 4'b0, 4'b0);
    apply(1, 0, 0, 0, 0, 4'b1111, 4'b0000);
    idle(); idle(); idle();
    apply(0, 0, 0, 0, 0, 4'b0, 4'b0);
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    apply(1, 0, 0, 0, 0, 4'b1111, 4'b0000);
    for (int t = 1; t <= 5; t++) begin
      idle();
      check($sformatf("rst_default_t%0d", t), 32'(enable), (t == 5) ? 32'hf : 32'h0);
    end

    // Randomized traffic against the model.
    apply(0, 0, 0, 0, 0, 4'b0, 4'b0);
    m_t = 0;
    model_step(0, 0, 0, 0, 0, 4'b0, 4'b0, e_en, e_run);
    for (int n = 0; n < 2000; n++) begin
      logic          rn, we, os;
      logic [1:0]    sel;
      logic [W-1:0]  per;
      logic [CH-1:0] st, sp;
      rn  = ($urandom_range(0, 199) != 0);
      we  = ($urandom_range(0, 4) == 0);
      sel = 2'($urandom_range(0, 3));
      per = W'($urandom_range(0, 9));
      os  = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        st[c] = ($urandom_range(0, 15) == 0);
        sp[c] = ($urandom_range(0, 31) == 0);
      end
      apply(rn, we, sel, per, os, st, sp);
      model_step(rn, we, sel, int'(per), os, st, sp, e_en, e_run);
      check($sformatf("rand%0d_enable", n), 32'(enable), 32'(e_en));
      check($sformatf("rand%0d_running", n), 32'(running), 32'(e_run));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule
